// File: rtl/fwd_scoreboard.sv
// Operand-forwarding and load-use hazard unit: tracks in-flight writers for DEPTH
// stages past decode and resolves NUM_SRC operands. Optional stats: FWD_SCOREBOARD_STATS_EN.
module fwd_scoreboard #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 3,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pipe_adv,
  input  logic                        flush,
  input  logic                        iss_valid,
  input  logic [REG_AW-1:0]           iss_rd,
  input  logic                        iss_we,
  input  logic                        iss_load,
  input  logic [NUM_SRC*REG_AW-1:0]   src_addr,
  input  logic [NUM_SRC*DATA_W-1:0]   src_rf_data,
  input  logic [DEPTH*DATA_W-1:0]     stage_data,
  output logic [NUM_SRC*DATA_W-1:0]   fwd_data,
  output logic [NUM_SRC*2-1:0]        fwd_sel,
  output logic                        hazard_stall
`ifdef FWD_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]                 stat_fwd_cnt,
  output logic [31:0]                 stat_stall_cnt
`endif
);

  logic [DEPTH-1:0]  tag_valid;
  logic [DEPTH-1:0]  tag_we;
  logic [DEPTH-1:0]  tag_load;
  logic [REG_AW-1:0] tag_rd [DEPTH];

  logic [REG_AW-1:0] cur_addr;
  logic              cur_hit;

  // Youngest matching stage wins; a load not yet producing its result forces a stall.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    hazard_stall = 1'b0;
    fwd_sel      = '0;
    fwd_data     = src_rf_data;
    cur_addr     = '0;
    cur_hit      = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cur_addr = src_addr[i*REG_AW +: REG_AW];
      cur_hit  = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        if (!cur_hit && tag_valid[k] && tag_we[k] &&
            tag_rd[k] == cur_addr && cur_addr != '0) begin
          cur_hit              = 1'b1;
          fwd_sel[i*2 +: 2]    = (k >= 2) ? 2'd3 : 2'(k + 1);
          if (tag_load[k] && k < LOAD_STAGE)
            hazard_stall = 1'b1;
          else
            fwd_data[i*DATA_W +: DATA_W] = stage_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages shift from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= '0;
    end else if (pipe_adv) begin
      for (int k = DEPTH - 1; k >= 1; k--)
        tag_valid[k] <= tag_valid[k-1] && !(k == 1 && flush);
      tag_valid[0] <= iss_valid && !hazard_stall && !flush;
    end else if (flush) begin
      tag_valid[0] <= 1'b0;
    end
  end

  // NOTE: only the valid bits need reset; the payload is ignored while its valid bit is low.
  always_ff @(posedge clk) begin
    if (pipe_adv) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        tag_rd[k]   <= tag_rd[k-1];
        tag_we[k]   <= tag_we[k-1];
        tag_load[k] <= tag_load[k-1];
      end
      tag_rd[0]   <= iss_rd;
      tag_we[0]   <= iss_we;
      tag_load[0] <= iss_load;
    end
  end

`ifdef FWD_SCOREBOARD_STATS_EN
  logic any_fwd;
  assign any_fwd = |fwd_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fwd_cnt   <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (pipe_adv && !hazard_stall && iss_valid && any_fwd && stat_fwd_cnt != 32'hFFFF_FFFF)
        stat_fwd_cnt <= stat_fwd_cnt + 32'd1;
      if (hazard_stall && pipe_adv && stat_stall_cnt != 32'hFFFF_FFFF)
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench for fwd_scoreboard: the driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fwd_scoreboard;
  localparam int DATA_W = 32, REG_AW = 5, NUM_SRC = 3, DEPTH = 3, LOAD_STAGE = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic pipe_adv, flush, iss_valid, iss_we, iss_load;
  logic [REG_AW-1:0]         iss_rd;
  logic [NUM_SRC*REG_AW-1:0] src_addr;
  logic [NUM_SRC*DATA_W-1:0] src_rf_data;
  logic [DEPTH*DATA_W-1:0]   stage_data;
  logic [NUM_SRC*DATA_W-1:0] fwd_data;
  logic [NUM_SRC*2-1:0]      fwd_sel;
  logic                      hazard_stall;
`ifdef FWD_SCOREBOARD_STATS_EN
  logic [31:0] stat_fwd_cnt, stat_stall_cnt;
`endif

  fwd_scoreboard #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC),
                   .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE)) dut (
    .clk(clk), .rst_n(rst_n), .pipe_adv(pipe_adv), .flush(flush),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_we(iss_we), .iss_load(iss_load),
    .src_addr(src_addr), .src_rf_data(src_rf_data), .stage_data(stage_data),
    .fwd_data(fwd_data), .fwd_sel(fwd_sel), .hazard_stall(hazard_stall)
`ifdef FWD_SCOREBOARD_STATS_EN
    , .stat_fwd_cnt(stat_fwd_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    int          port;
    logic [1:0]  sel;
    bit          chk_sel;
    logic [31:0] data;
    logic        stall;
    bit          is_stat;
    logic [31:0] sfwd;
    logic [31:0] sstall;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  localparam logic [31:0] RF0 = 32'h11, RF1 = 32'h22, RF2 = 32'h33;
  localparam logic [31:0] SD0 = 32'hAAAA, SD1 = 32'hBBBB, SD2 = 32'hCCCC;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: compare every expectation queued for the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc != cyc) begin
          check({e.name, ".late"}, 32'(cyc), 32'(e.cyc));
        end else if (e.is_stat) begin
`ifdef FWD_SCOREBOARD_STATS_EN
          check({e.name, ".fwd_cnt"}, stat_fwd_cnt, e.sfwd);
          check({e.name, ".stall_cnt"}, stat_stall_cnt, e.sstall);
`endif
        end else begin
          if (e.chk_sel) check({e.name, ".sel"}, 32'(fwd_sel[e.port*2 +: 2]), 32'(e.sel));
          check({e.name, ".data"}, fwd_data[e.port*DATA_W +: DATA_W], e.data);
          check({e.name, ".stall"}, 32'(hazard_stall), 32'(e.stall));
        end
      end
    end
  end

  function automatic void ep(input string name, input int port, input logic [1:0] sel,
                             input logic [31:0] data, input logic stall, input bit chk_sel);
    exp_t e;
    e = '{cyc: cyc, name: name, port: port, sel: sel, chk_sel: chk_sel, data: data,
          stall: stall, is_stat: 1'b0, sfwd: '0, sstall: '0};
    q.push_back(e);
  endfunction

  function automatic void es(input string name, input logic [31:0] f, input logic [31:0] s);
    exp_t e;
    e = '{cyc: cyc, name: name, port: 0, sel: '0, chk_sel: 1'b0, data: '0,
          stall: 1'b0, is_stat: 1'b1, sfwd: f, sstall: s};
    q.push_back(e);
  endfunction

  task automatic idle();
    pipe_adv = 1'b1; flush = 1'b0;
    iss_valid = 1'b0; iss_rd = '0; iss_we = 1'b0; iss_load = 1'b0;
    src_addr = '0;
  endtask

  task automatic src(input int p, input logic [REG_AW-1:0] a);
    src_addr[p*REG_AW +: REG_AW] = a;
  endtask

  task automatic issue(input logic [REG_AW-1:0] rd, input logic we, input logic ld);
    iss_valid = 1'b1; iss_rd = rd; iss_we = we; iss_load = ld;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    src_rf_data = {RF2, RF1, RF0};
    stage_data  = {SD2, SD1, SD0};
    idle();
    rst_n = 1'b0;
    src(0, 5);
    @(posedge clk); #1;
    ep("reset", 0, 2'd0, RF0, 1'b0, 1'b1);
    nxt(); rst_n = 1'b1; src(0, 5);
    ep("post_reset", 0, 2'd0, RF0, 1'b0, 1'b1);

    // ALU writer r5 walking through every stage
    nxt(); issue(5, 1, 0); src(0, 5); ep("a_empty", 0, 2'd0, RF0, 1'b0, 1'b1);
    nxt(); src(0, 5); ep("a_s0", 0, 2'd1, SD0, 1'b0, 1'b1);
    nxt(); src(0, 5); ep("a_s1", 0, 2'd2, SD1, 1'b0, 1'b1);
    nxt(); src(0, 5); ep("a_s2", 0, 2'd3, SD2, 1'b0, 1'b1);
    nxt(); src(0, 5); ep("a_gone", 0, 2'd0, RF0, 1'b0, 1'b1);

    // Two r7 writers (stages 0 and 2), then an r0 writer
    nxt(); issue(7, 1, 0);
    nxt();
    nxt(); issue(7, 1, 0);
    nxt(); src(0, 7); src(1, 7); issue(0, 1, 0);
    ep("b_young", 0, 2'd1, SD0, 1'b0, 1'b1);
    ep("b_young_p1", 1, 2'd1, SD0, 1'b0, 1'b1);
    nxt(); src(0, 7); src(2, 0);
    ep("b_r0", 2, 2'd0, RF2, 1'b0, 1'b1);
    ep("b_older", 0, 2'd2, SD1, 1'b0, 1'b1);
    nxt(); nxt(); nxt();

    // Load-use on r9: one stall cycle, dependent r10 held back then enters
    issue(9, 1, 1); ep("c_pre", 0, 2'd0, RF0, 1'b0, 1'b1);
    nxt(); src(0, 9); issue(10, 1, 0); ep("c_stall", 0, 2'd0, RF0, 1'b1, 1'b0);
    nxt(); src(0, 9); src(1, 10); issue(10, 1, 0);
    ep("c_after", 0, 2'd2, SD1, 1'b0, 1'b1);
    ep("c_bubble", 1, 2'd0, RF1, 1'b0, 1'b1);
    nxt(); src(0, 9); src(1, 10);
    ep("c_dep_s0", 1, 2'd1, SD0, 1'b0, 1'b1);
    ep("c_ld_s2", 0, 2'd3, SD2, 1'b0, 1'b1);
    nxt(); nxt(); nxt();

    // Flush with advance: kills entering r4 and outgoing stage-0 r12
    issue(12, 1, 0);
    nxt(); issue(4, 1, 0); flush = 1'b1;
    nxt(); src(0, 4); src(1, 12);
    ep("d_r4", 0, 2'd0, RF0, 1'b0, 1'b1);
    ep("d_old_s0", 1, 2'd0, RF1, 1'b0, 1'b1);
    nxt(); src(0, 4); ep("d_r4_later", 0, 2'd0, RF0, 1'b0, 1'b1);
    nxt(); src(0, 4); ep("d_r4_last", 0, 2'd0, RF0, 1'b0, 1'b1);

    // Freeze for three cycles: tags hold, issue ignored
    nxt(); issue(6, 1, 0);
    nxt(); pipe_adv = 1'b0; issue(8, 1, 0); src(0, 6); ep("e_frz0", 0, 2'd1, SD0, 1'b0, 1'b1);
    nxt(); pipe_adv = 1'b0; src(0, 6); ep("e_frz1", 0, 2'd1, SD0, 1'b0, 1'b1);
    nxt(); pipe_adv = 1'b0; src(0, 6); ep("e_frz2", 0, 2'd1, SD0, 1'b0, 1'b1);
    nxt(); src(0, 6); src(1, 8);
    ep("e_resume", 0, 2'd1, SD0, 1'b0, 1'b1);
    ep("e_no_r8", 1, 2'd0, RF1, 1'b0, 1'b1);
    nxt(); src(0, 6); ep("e_adv", 0, 2'd2, SD1, 1'b0, 1'b1);

    // Flush while frozen clears stage 0 in place
    nxt(); issue(13, 1, 0);
    nxt(); pipe_adv = 1'b0; flush = 1'b1; src(0, 13); ep("f_before", 0, 2'd1, SD0, 1'b0, 1'b1);
    nxt(); pipe_adv = 1'b0; src(0, 13); ep("f_cleared", 0, 2'd0, RF0, 1'b0, 1'b1);

    // Mid-run reset discards in-flight tags
    nxt(); issue(14, 1, 0);
    nxt(); src(0, 14); ep("g_pre", 0, 2'd1, SD0, 1'b0, 1'b1);
    nxt(); rst_n = 1'b0; src(0, 14); ep("g_reset", 0, 2'd0, RF0, 1'b0, 1'b1);
    nxt(); rst_n = 1'b1; src(0, 14); ep("g_after", 0, 2'd0, RF0, 1'b0, 1'b1);

`ifdef FWD_SCOREBOARD_STATS_EN
    // One load-use stall, then two forwarding issue cycles
    nxt(); issue(9, 1, 1);
    nxt(); src(0, 9); issue(10, 1, 0); ep("s_stall", 0, 2'd0, RF0, 1'b1, 1'b0);
    nxt(); src(0, 9); issue(10, 1, 0); ep("s_fwd1", 0, 2'd2, SD1, 1'b0, 1'b1);
    nxt(); src(0, 10); issue(11, 1, 0); ep("s_fwd2", 0, 2'd1, SD0, 1'b0, 1'b1);
    nxt(); es("s_counts", 32'd2, 32'd1);
    nxt(); rst_n = 1'b0; es("s_reset", 32'd0, 32'd0);
    nxt(); rst_n = 1'b1;
`endif

    nxt(); nxt();
    @(negedge clk); #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised operand-forwarding and load-use hazard unit for the pipelined datapath. It replaces static, externally decoded forward selects with an internal destination-tag pipeline that tracks every in-flight writer for DEPTH stages past decode. It resolves NUM_SRC source operands per cycle against those tags, returns the forwarded data, and raises a stall for load-use hazards. It sits between decode/register-file read and the EX-stage operand muxes.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register address width; register 0 is hardwired zero
- NUM_SRC, 3, source operand ports (e.g. rs, rt, store data)
- DEPTH, 3, tracked stages: index 0 = EX/MEM, DEPTH-1 = WB
- LOAD_STAGE, 1, first stage index at which a load's result is valid (1..DEPTH-1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pipe_adv  in  1  pipeline advances this cycle; 0 freezes all tags
- flush  in  1  kill the entry entering stage 0 and the entry currently in stage 0
- iss_valid  in  1  instruction leaving decode into EX
- iss_rd  in  REG_AW  its destination register
- iss_we  in  1  it writes the register file
- iss_load  in  1  it is a load
- src_addr  in  NUM_SRC*REG_AW  source register per port, port i at bits [i*REG_AW +: REG_AW]
- src_rf_data  in  NUM_SRC*DATA_W  register-file read data per port
- stage_data  in  DEPTH*DATA_W  result bus of each tracked stage
- fwd_data  out  NUM_SRC*DATA_W  resolved operand per port
- fwd_sel  out  NUM_SRC*2  per port: 0 = register file, 1 = stage 0, 2 = stage 1, 3 = stage ≥ 2 (diagnostic)
- hazard_stall  out  1  load-use hazard; decode must hold and the block inserts a bubble

## Operation
- Tag entry per stage: {valid, rd, we, load}. Reset clears all valid bits.
- Match for port i at stage k: valid && we && rd == src_addr[i] && src_addr[i] != 0.
- Priority: youngest match (lowest k) wins. With no match, fwd_data = src_rf_data and fwd_sel = 0.
- Load-use: the winning match is a load at stage k < LOAD_STAGE → hazard_stall = 1. That port's fwd_data = src_rf_data. hazard_stall is the OR over all ports.
- Tag update on clk when pipe_adv = 1:
  - stage[k] ← stage[k-1] for k ≥ 1.
  - stage[0] ← bubble if (hazard_stall || flush || !iss_valid), else {1, iss_rd, iss_we, iss_load}.
- flush with pipe_adv = 1: stage 1 receives a bubble instead of the old stage 0 entry.
- flush with pipe_adv = 0: stage 0 valid is cleared in place. Other stages hold.
- pipe_adv = 0 without flush: all tags hold. hazard_stall is still evaluated combinationally.
- Writes with iss_we = 0 or iss_rd = 0 enter as valid entries but never match.

## Timing
- Resolution is purely combinational from src_addr, tags and data buses. fwd_data and hazard_stall are valid in the same cycle.
- Instruction issued at edge N occupies stage 0 after edge N. It is forwardable to the operand resolved in cycle N+1. It reaches stage k after edge N+k and leaves after edge N+DEPTH.
- A load issued at N followed immediately by a dependent instruction stalls for LOAD_STAGE cycles. With the default LOAD_STAGE = 1, that is 1 cycle.
- Reset (async assert, sync release): all tags invalid. Consequently fwd_sel = 0, fwd_data = src_rf_data, hazard_stall = 0, and stats counters = 0. Reset mid-operation discards all in-flight tags.

## Configuration
- FWD_SCOREBOARD_STATS_EN defined: adds outputs stat_fwd_cnt and stat_stall_cnt, each 32 bits.
  - stat_fwd_cnt increments per cycle with pipe_adv && !hazard_stall && iss_valid when any port forwards (fwd_sel ≠ 0).
  - stat_stall_cnt increments per cycle with hazard_stall && pipe_adv.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Not defined: the counters and ports are absent, and there is no extra logic.

## Test plan
- Reset, then src_addr port0 = 5, src_rf_data = 0x11 → fwd_sel 0, fwd_data 0x11, hazard_stall 0.
- Issue ALU write r5, next cycle read r5 with stage_data[0] = 0xAAAA → port0 fwd_sel 1, fwd_data 0xAAAA. One cycle later, with stage_data[1] = 0xBBBB → fwd_sel 2, fwd_data 0xBBBB.
- Two writers to r7 in stages 0 and 2 (data 0x1, 0x3) → port resolves 0x1. Reading r0 with a matching r0 writer → fwd_sel 0, data = src_rf_data.
- Load to r9, then dependent read of r9 → hazard_stall 1 for one cycle with a bubble in stage 0. Next cycle fwd_sel 2, data = stage_data[1], stall 0.
- Write r4 issued with flush = 1 → no later cycle forwards r4. With pipe_adv = 0 for 3 cycles, tags hold and fwd_sel is unchanged.
- With FWD_SCOREBOARD_STATS_EN: one load-use stall plus 2 forwarding cycles → stat_stall_cnt = 1, stat_fwd_cnt = 2. Assert rst_n mid-run → both 0.
